// File: rtl/seq_multiplier_radix_if.sv
// Operand/result bundle between a requester and the sequential multiplier.
// Latency: none, wires only.
// Backpressure: start is only taken while busy is low; results are never stalled.
interface seq_multiplier_radix_if #(
    parameter int N = 8
) ();
    logic           start;
    logic           abort;
    logic           signed_mode;
    logic [N-1:0]   multiplier;
    logic [N-1:0]   multiplicand;
    logic           busy;
    logic           ready;
    logic [2*N-1:0] product;

    // Requester side: issues operations, observes status and result
    modport master (
        output start, abort, signed_mode, multiplier, multiplicand,
        input  busy, ready, product
    );

    // Multiplier side
    modport slave (
        input  start, abort, signed_mode, multiplier, multiplicand,
        output busy, ready, product
    );
endinterface

// File: rtl/seq_multiplier_radix.sv
// Iterative shift-add multiplier retiring K multiplier bits per cycle, signed or unsigned.
// Latency: max(1, ceil(msb(|B|)+1)/K)) edges from accepted start to ready pulse.
// Backpressure: start ignored while busy; abort cancels the running operation without ready.
module seq_multiplier_radix #(
    parameter int N = 8,
    parameter int K = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_multiplier_radix_if.slave bus
);
    localparam int STEPS = N / K;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t         r_state;
    logic [2*N-1:0] r_a;        // multiplicand magnitude, shifted left K per step
    logic [N-1:0]   r_b;        // multiplier magnitude, shifted right K per step
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;      // result must be negated on completion
    logic           r_busy;
    logic           r_ready;
    logic [2*N-1:0] r_product;

    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic           w_neg;
    logic [2*N-1:0] w_addend;
    logic [2*N-1:0] w_acc_next;
    logic [N-1:0]   w_b_next;
    logic [CW-1:0]  w_cnt_next;
    logic           w_done;
    logic [2*N-1:0] w_result;

    // Operand magnitudes at latch time; -2^(N-1) maps to 2^(N-1), which still fits in N bits unsigned
    always_comb begin
        w_mag_a = bus.multiplicand;
        w_mag_b = bus.multiplier;
        w_neg   = 1'b0;
        if (bus.signed_mode) begin
            if (bus.multiplicand[N-1]) w_mag_a = ~bus.multiplicand + ONE_N;
            if (bus.multiplier[N-1])   w_mag_b = ~bus.multiplier + ONE_N;
            w_neg = bus.multiplicand[N-1] ^ bus.multiplier[N-1];
        end
    end

    // Partial products for the K low multiplier bits of this step
    always_comb begin
        w_addend = '0;
        for (int i = 0; i < K; i++) begin
            if (r_b[i]) w_addend = w_addend + (r_a << i);
        end
    end

    // Next-step values and completion: multiplier exhausted or all N/K steps taken
    always_comb begin
        w_acc_next = r_acc + w_addend;
        w_b_next   = r_b >> K;
        w_cnt_next = r_cnt + CW'(1);
        w_done     = (w_b_next == '0) || (w_cnt_next == CW'(STEPS));
        w_result   = r_neg ? (~w_acc_next + ONE_2N) : w_acc_next;
    end

    // Control FSM and datapath registers; abort wins over a same-edge completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_product <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= {{N{1'b0}}, w_mag_a};
                        r_b     <= w_mag_b;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_a   <= r_a << K;
                        r_b   <= w_b_next;
                        r_cnt <= w_cnt_next;
                        if (w_done) begin
                            r_product <= w_result;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.ready   = r_ready;
    assign bus.product = r_product;
endmodule

// File: tb/tb_seq_multiplier_radix.sv
// Directed bench for two multiplier instances (N=8 with K=2 and K=1).
// Expected products and latencies come from an independent arithmetic model via a scoreboard queue.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_multiplier_radix;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_multiplier_radix_if #(.N(8)) b2 ();
    seq_multiplier_radix_if #(.N(8)) b1 ();

    seq_multiplier_radix #(.N(8), .K(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    seq_multiplier_radix #(.N(8), .K(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] q2[$];
    logic [15:0] q1[$];
    int rc2 = 0;
    int rc1 = 0;

    // Count ready pulses as seen just before each rising edge
    always @(posedge clk) begin
        if (b2.ready) rc2 <= rc2 + 1;
        if (b1.ready) rc1 <= rc1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sm);
        logic signed [15:0] sa, sb, sp;
        if (sm) begin
            sa = $signed({{8{a[7]}}, a});
            sb = $signed({{8{b[7]}}, b});
            sp = sa * sb;
            return sp;
        end
        return {8'h00, a} * {8'h00, b};
    endfunction

    function automatic int lat(input logic [7:0] b, input logic sm, input int k);
        logic [7:0] mag;
        int msb;
        mag = (sm && b[7]) ? (8'h00 - b) : b;
        msb = -1;
        for (int i = 0; i < 8; i++) if (mag[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 1 + k - 1) / k;
    endfunction

    function automatic logic g_ready(input int sel);
        return (sel == 1) ? b1.ready : b2.ready;
    endfunction
    function automatic logic g_busy(input int sel);
        return (sel == 1) ? b1.busy : b2.busy;
    endfunction
    function automatic logic [15:0] g_prod(input int sel);
        return (sel == 1) ? b1.product : b2.product;
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b, input logic sm);
        if (sel == 1) begin
            b1.start = st; b1.multiplicand = a; b1.multiplier = b; b1.signed_mode = sm;
        end else begin
            b2.start = st; b2.multiplicand = a; b2.multiplier = b; b2.signed_mode = sm;
        end
    endtask

    // Step falling edges until ready is seen; cycle count is edges elapsed
    task automatic wait_ready(input int sel, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 40 && !ok) begin
            @(negedge clk);
            cyc++;
            if (g_ready(sel)) ok = 1'b1;
        end
    endtask

    task automatic pop_chk(input int sel, input string tag);
        logic [15:0] e;
        if (sel == 1) begin
            if (q1.size() == 0) begin chk({tag, "_sb_empty"}, 32'd0, 32'd1); return; end
            e = q1.pop_front();
        end else begin
            if (q2.size() == 0) begin chk({tag, "_sb_empty"}, 32'd0, 32'd1); return; end
            e = q2.pop_front();
        end
        chk({tag, "_product"}, {16'h0, g_prod(sel)}, {16'h0, e});
    endtask

    // One full operation: issue, scramble operands while busy, check latency/result/pulse width
    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sm, input string tag);
        int  cyc;
        bit  ok;
        int  k;
        k = (sel == 1) ? 1 : 2;
        if (sel == 1) q1.push_back(model(a, b, sm)); else q2.push_back(model(a, b, sm));
        @(negedge clk);
        set_in(sel, 1'b1, a, b, sm);
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, g_busy(sel)}, 32'd1);
        set_in(sel, 1'b0, ~a, 8'($urandom), ~sm);
        wait_ready(sel, cyc, ok);
        chk({tag, "_timeout"}, {31'd0, ok}, 32'd1);
        chk({tag, "_latency"}, cyc, lat(b, sm, k));
        pop_chk(sel, tag);
        chk({tag, "_busy_at_ready"}, {31'd0, g_busy(sel)}, 32'd0);
        @(negedge clk);
        chk({tag, "_ready_width"}, {31'd0, g_ready(sel)}, 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  rc0;
        logic [7:0] ra, rb;
        logic rs;
        b2.abort = 1'b0;
        b1.abort = 1'b0;
        set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset state
        #12;
        chk("reset_busy", {31'd0, b2.busy}, 32'd0);
        chk("reset_ready", {31'd0, b2.ready}, 32'd0);
        chk("reset_product", {16'h0, b2.product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned worst case, early termination, zero multiplier
        run_op(2, 8'd200, 8'd255, 1'b0, "u200x255");
        run_op(2, 8'd13, 8'd5, 1'b0, "u13x5");
        run_op(2, 8'd13, 8'd0, 1'b0, "u13x0");

        // Signed on K=1, including the most negative squared, and the same bits unsigned
        run_op(1, 8'hF9, 8'd3, 1'b1, "s_m7x3");
        run_op(1, 8'h80, 8'h80, 1'b1, "s_m128sq");
        run_op(1, 8'hF9, 8'd3, 1'b0, "u249x3");
        run_op(2, 8'h80, 8'h7F, 1'b1, "s_m128x127");
        run_op(2, 8'h80, 8'h80, 1'b1, "s2_m128sq");
        run_op(1, 8'hFF, 8'h80, 1'b1, "s_m1xm128");
        run_op(2, 8'hF9, 8'h00, 1'b1, "s_negzero");

        // Random mix on both instances
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            run_op(1 + (i % 2), ra, rb, rs, "rand");
        end

        // start held high: each ready cycle accepts the next operation
        rc0 = rc2;
        @(negedge clk);
        set_in(2, 1'b1, 8'd3, 8'd3, 1'b0);
        for (int p = 0; p < 3; p++) begin
            q2.push_back(model(8'd3, 8'd3, 1'b0));
            wait_ready(2, cyc, ok);
            chk("hold_timeout", {31'd0, ok}, 32'd1);
            pop_chk(2, "hold");
            chk("hold_busy_at_ready", {31'd0, b2.busy}, 32'd0);
            if (p < 2) begin
                @(negedge clk);
                chk("hold_reaccept_busy", {31'd0, b2.busy}, 32'd1);
                chk("hold_reaccept_ready", {31'd0, b2.ready}, 32'd0);
            end
        end
        set_in(2, 1'b0, 8'd3, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_idle", {31'd0, b2.busy}, 32'd0);
        chk("hold_pulses", rc2 - rc0, 32'd3);

        // Abort on third busy cycle: no ready, product retained
        run_op(1, 8'd5, 8'd6, 1'b0, "pre_abort");
        rc0 = rc1;
        @(negedge clk);
        set_in(1, 1'b1, 8'd100, 8'd200, 1'b0);
        @(negedge clk);
        set_in(1, 1'b0, 8'd100, 8'd200, 1'b0);
        @(negedge clk);
        @(negedge clk);
        b1.abort = 1'b1;
        @(negedge clk);
        b1.abort = 1'b0;
        chk("abort_busy", {31'd0, b1.busy}, 32'd0);
        chk("abort_ready", {31'd0, b1.ready}, 32'd0);
        chk("abort_product", {16'h0, b1.product}, 32'd30);
        repeat (10) @(negedge clk);
        chk("abort_no_ready", rc1 - rc0, 32'd0);
        chk("abort_product_hold", {16'h0, b1.product}, 32'd30);
        run_op(1, 8'd100, 8'd200, 1'b0, "post_abort");

        // Asynchronous reset mid-operation
        @(negedge clk);
        set_in(1, 1'b1, 8'd100, 8'd200, 1'b0);
        @(negedge clk);
        set_in(1, 1'b0, 8'd100, 8'd200, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, b1.busy}, 32'd0);
        chk("arst_ready", {31'd0, b1.ready}, 32'd0);
        chk("arst_product", {16'h0, b1.product}, 32'd0);
        chk("arst_product_k2", {16'h0, b2.product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rc0 = rc1;
        repeat (12) @(negedge clk);
        chk("arst_no_ready", rc1 - rc0, 32'd0);
        chk("arst_idle", {31'd0, b1.busy}, 32'd0);
        chk("arst_product_hold", {16'h0, b1.product}, 32'd0);
        run_op(1, 8'd3, 8'd3, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
